// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the UART transceiver
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF  = 50_000_000;
  localparam int unsigned BAUD_RATE_DEF = 9600;
  localparam int unsigned BIT_CNT_DEF   = CLK_FREQ_DEF / BAUD_RATE_DEF;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - baud counter producing half-bit and full-bit ticks
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CNT = BIT_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam int unsigned CW = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CNT / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter sits at zero while disabled so every enable starts a fresh bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick_o = en_i && (cnt_q == HALF);
  assign full_tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART receiver and transmitter
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE = BAUD_RATE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       uart_rx_done,
  input  logic [7:0] tx_data,
  input  logic       tx_start
);

  localparam int unsigned BIT_CNT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BW      = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  // ---------------------------------------------------------------- RX path
  logic                 rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic                 rx_fall;
  uart_state_e          rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_tmr_en, rx_tmr_clr, rx_half_tick, rx_full_tick;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= uart_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  assign rx_fall   = rx_prev_q & ~rx_sync2_q;
  assign rx_tmr_en = (rx_state_q != IDLE);

  uart_bit_timer #(.BIT_CNT(BIT_CNT)) u_rx_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (rx_tmr_en),
    .clr_i      (rx_tmr_clr),
    .half_tick_o(rx_half_tick),
    .full_tick_o(rx_full_tick)
  );

  // RX next state: the timer is restarted at mid-start so later samples land mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    rx_tmr_clr = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_fall) rx_state_d = START;
      end
      START: begin
        if (rx_half_tick) begin
          rx_tmr_clr = 1'b1;
          if (rx_sync2_q) begin
            rx_state_d = IDLE;
          end else begin
            rx_state_d = DATA;
            rx_bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (rx_full_tick) begin
          rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == LAST_BIT) rx_state_d = STOP;
        end
      end
      STOP: begin
        if (rx_full_tick) begin
          rx_state_d = IDLE;
          if (rx_sync2_q == STOP_LEVEL) begin
            rx_data_d = rx_shift_q;
            rx_done_d = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // RX state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign uart_rx_done = rx_done_q;

  // ---------------------------------------------------------------- TX path
  logic                 tx_start_q;
  logic                 tx_edge;
  uart_state_e          tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_tmr_en, tx_half_tick_unused, tx_full_tick;

  assign tx_edge   = tx_start & ~tx_start_q;
  assign tx_tmr_en = (tx_state_q != IDLE);

  uart_bit_timer #(.BIT_CNT(BIT_CNT)) u_tx_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (tx_tmr_en),
    .clr_i      (1'b0),
    .half_tick_o(tx_half_tick_unused),
    .full_tick_o(tx_full_tick)
  );

  // TX next state: the line is computed one cycle ahead so uart_tx comes straight from a flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      IDLE: begin
        tx_line_d = 1'b1;
        if (tx_edge) begin
          tx_shift_d = tx_data;
          tx_state_d = START;
          tx_line_d  = 1'b0;
        end
      end
      START: begin
        if (tx_full_tick) begin
          tx_state_d = DATA;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end
      end
      DATA: begin
        if (tx_full_tick) begin
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = STOP;
            tx_line_d  = STOP_LEVEL;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
      STOP: begin
        if (tx_full_tick) begin
          tx_state_d = IDLE;
          tx_line_d  = 1'b1;
        end
      end
      default: begin
        tx_state_d = IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // TX state, datapath and start-edge history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start_q <= 1'b0;
      tx_state_q <= IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_start_q <= tx_start;
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx = tx_line_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - self-checking bench for uart_transceiver
module tb_uart_transceiver;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BC        = CLK_FREQ / BAUD_RATE;

  typedef struct {
    logic [7:0] b;
    longint     lo;
    longint     hi;
  } rx_exp_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       uart_rx  = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       uart_tx;
  logic       uart_rx_done;
  logic [7:0] rx_data;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  // Transmit model: a frame is a 10-bit word replayed one bit per BC cycles.
  longint     tx_beg     = -1_000_000;
  longint     tx_end     = -1_000_000;
  logic [9:0] tx_word    = 10'h3FF;
  logic       prev_start = 1'b0;
  logic       exp_tx     = 1'b1;

  // Receive model: bytes that must appear, each with an arrival window.
  rx_exp_t    pend[$];
  rx_exp_t    cur;
  logic [7:0] exp_rx_data = 8'h00;

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .uart_tx     (uart_tx),
    .rx_data     (rx_data),
    .uart_rx_done(uart_rx_done),
    .tx_data     (tx_data),
    .tx_start    (tx_start)
  );

  always #10 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update on every rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      prev_start = 1'b0;
      tx_beg     = -1_000_000;
      tx_end     = -1_000_000;
      exp_tx     = 1'b1;
    end else begin
      if (tx_start && !prev_start && cyc > tx_end) begin
        tx_beg  = cyc;
        tx_end  = cyc + 10 * BC;
        tx_word = {1'b1, tx_data, 1'b0};
      end
      prev_start = tx_start;
      exp_tx = (cyc >= tx_beg && cyc < tx_end) ? tx_word[int'((cyc - tx_beg) / BC)] : 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      exp_rx_data = 8'h00;
      check1("reset_uart_tx", uart_tx, 1'b1);
      check8("reset_rx_data", rx_data, 8'h00);
      check1("reset_rx_done", uart_rx_done, 1'b0);
    end else begin
      check1("uart_tx", uart_tx, exp_tx);
      if (pend.size() == 0) begin
        check1("rx_done_spurious", uart_rx_done, 1'b0);
        check8("rx_data_hold", rx_data, exp_rx_data);
      end else if (uart_rx_done) begin
        cur = pend.pop_front();
        check1("rx_done_early", (cyc >= cur.lo), 1'b1);
        check8("rx_data_on_done", rx_data, cur.b);
        exp_rx_data = cur.b;
      end else begin
        check8("rx_data_hold", rx_data, exp_rx_data);
        if (cyc > pend[0].hi) begin
          check1("rx_done_missing", uart_rx_done, 1'b1);
          cur = pend.pop_front();
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] w;
    rx_exp_t    e;
    w = {stop_bit, b, 1'b0};
    if (stop_bit) begin
      e.b  = b;
      e.lo = cyc + 9 * BC;
      e.hi = cyc + 10 * BC;
      pend.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      uart_rx = w[i];
      step(BC);
    end
    uart_rx = 1'b1;
    if (!stop_bit) step(2 * BC);
  endtask

  task automatic send_tx(input logic [7:0] b, input int hold);
    tx_data  = b;
    tx_start = 1'b1;
    step(hold);
    tx_start = 1'b0;
  endtask

  // Hand-computed frame for 0x32, sampled at bit midpoints, with a busy-time start request.
  task automatic tx_literal_0x32;
    logic [9:0] want;
    want     = 10'b1001100100;
    tx_data  = 8'h32;
    tx_start = 1'b1;
    step(1);
    check1("tx_start_bit_latency", uart_tx, 1'b0);
    step(4);
    tx_start = 1'b0;
    step(BC / 2 - 4);
    for (int k = 0; k < 10; k++) begin
      check1("tx_literal_bit", uart_tx, want[k]);
      if (k == 4) begin
        step(2);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        step(3);
        tx_start = 1'b0;
        step(BC - 5);
      end else if (k < 9) begin
        step(BC);
      end
    end
    step(BC / 2);
    check1("tx_idle_after_frame", uart_tx, 1'b1);
    step(2 * BC);
    check1("tx_no_second_frame", uart_tx, 1'b1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(10);
    rst_n = 1'b1;
    step(2);

    send_rx(8'h31, 1'b1);
    step(2);
    check8("rx_literal_31", rx_data, 8'h31);

    tx_literal_0x32();

    send_rx(8'hA5, 1'b0);
    check8("rx_framing_keeps_data", rx_data, 8'h31);
    send_rx(8'h5A, 1'b1);
    step(2);
    check8("rx_literal_5a", rx_data, 8'h5A);

    uart_rx = 1'b0;
    step(4);
    uart_rx = 1'b1;
    step(2 * BC);
    send_rx(8'hC3, 1'b1);
    step(2);
    check8("rx_after_glitch", rx_data, 8'hC3);

    fork
      send_rx(8'h31, 1'b1);
      send_tx(8'h32, 5);
    join
    step(11 * BC);
    check8("rx_duplex_31", rx_data, 8'h31);

    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send_rx(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
          step(int'($urandom_range(1, BC)));
        end
      end
      begin
        for (int j = 0; j < 8; j++) begin
          step(int'($urandom_range(1, 12 * BC)));
          send_tx(8'($urandom_range(0, 255)), int'($urandom_range(1, 5)));
          tx_data = 8'($urandom_range(0, 255));
        end
      end
    join
    step(11 * BC);

    send_tx(8'h96, 2);
    step(BC);
    check1("tx_low_before_reset", uart_tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check1("reset_aborts_tx", uart_tx, 1'b1);
    step(5);
    rst_n = 1'b1;
    step(12 * BC);
    check1("tx_idle_after_reset", uart_tx, 1'b1);
    check8("rx_data_after_reset", rx_data, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
